control_sequencer: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/control_sequencer_if.sv | 31 +++
 rtl/reg_sel_decoder.sv | 22 ++
 rtl/control_sequencer.sv | 118 +++++++++++
 tb/tb_control_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit constants: IR field layout, opcodes, ALU function codes, FSM encoding.
// Pure declarations; no logic.
package cpu_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int RC_LSB  = 15;

    typedef logic [4:0] opcode_t;
    typedef logic [3:0] reg_field_t;
    typedef logic [3:0] alu_code_t;

    // Upper IR slice [OPC_MSB:RC_LSB], MSB first.
    typedef struct packed {
        opcode_t    opcode;
        reg_field_t ra;
        reg_field_t rb;
        reg_field_t rc;
    } ir_fields_t;

    localparam opcode_t OPC_ADD  = 5'b00011;
    localparam opcode_t OPC_SUB  = 5'b00100;
    localparam opcode_t OPC_AND  = 5'b00101;
    localparam opcode_t OPC_OR   = 5'b00110;
    localparam opcode_t OPC_SHR  = 5'b00111;
    localparam opcode_t OPC_SHL  = 5'b01000;
    localparam opcode_t OPC_ROR  = 5'b01001;
    localparam opcode_t OPC_ROL  = 5'b01010;
    localparam opcode_t OPC_NOP  = 5'b11010;
    localparam opcode_t OPC_HALT = 5'b11011;

    localparam alu_code_t ALU_NONE = 4'd0;
    localparam alu_code_t ALU_ADD  = 4'd1;
    localparam alu_code_t ALU_SUB  = 4'd2;
    localparam alu_code_t ALU_AND  = 4'd3;
    localparam alu_code_t ALU_OR   = 4'd4;
    localparam alu_code_t ALU_SHR  = 4'd5;
    localparam alu_code_t ALU_SHL  = 4'd6;
    localparam alu_code_t ALU_ROR  = 4'd7;
    localparam alu_code_t ALU_ROL  = 4'd8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    // ALU_NONE doubles as "not an ALU opcode".
    function automatic alu_code_t alu_decode(input opcode_t opc);
        case (opc)
            OPC_ADD: return ALU_ADD;
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            OPC_SHR: return ALU_SHR;
            OPC_SHL: return ALU_SHL;
            OPC_ROR: return ALU_ROR;
            OPC_ROL: return ALU_ROL;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR readback and memory-ready in, every control strobe out.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ALU_OP_W = 4
);
    logic                run;
    logic [DATA_W-1:0]   ir;
    logic                mem_ready;
    logic                pc_out, mar_in, inc_pc, pc_in, read, mdr_in;
    logic                mdr_out, ir_in, y_in, z_in, zlow_out;
    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_done;
    logic                illegal;
    logic                halted;

    modport master (
        input  run, ir, mem_ready,
        output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, r_in, r_out, alu_op, instr_done, illegal, halted
    );

    modport slave (
        output run, ir, mem_ready,
        input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, r_in, r_out, alu_op, instr_done, illegal, halted
    );
endinterface

// File: rtl/reg_sel_decoder.sv
// 4-bit register field to one-hot select; combinational, zero latency.
// Output is all-zero when disabled or when the field names a register that does not exist.
module reg_sel_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          field,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot,
    output logic                out_of_range
);
    logic [31:0] field_ext;

    assign field_ext    = {28'd0, field};
    assign out_of_range = field_ext >= 32'(NUM_REGS);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (field_ext == 32'(i));
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute FSM for the single-bus datapath; strobes are Moore-decoded from state and live IR.
// ALU instruction takes 6 cycles, NOP/illegal 4; each mem_ready=0 cycle in T1 stretches the fetch by one.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ALU_OP_W = 4
) (
    input logic                 clk,
    input logic                 clr,
    control_sequencer_if.master bus
);
    logic [2:0]          state, state_nxt;
    ir_fields_t          fld;
    alu_code_t           alu_code;
    logic                is_nop, is_halt, alu_ok;
    logic                ra_oor, rb_oor, rc_oor;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
    logic [DATA_W-1:0]   ir_unused_bits;

    assign fld            = ir_fields_t'(bus.ir[OPC_MSB:RC_LSB]);
    assign ir_unused_bits = bus.ir;
    assign alu_code       = alu_decode(fld.opcode);
    assign is_nop         = (fld.opcode == OPC_NOP);
    assign is_halt        = (fld.opcode == OPC_HALT);
    // Register fields only matter for ALU instructions; NOP and HALT ignore them.
    assign alu_ok         = (alu_code != ALU_NONE) && !(ra_oor || rb_oor || rc_oor);

    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_dec_ra (
        .field(fld.ra), .en(state == S_T5), .onehot(ra_oh), .out_of_range(ra_oor)
    );
    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rb (
        .field(fld.rb), .en((state == S_T3) && alu_ok), .onehot(rb_oh), .out_of_range(rb_oor)
    );
    reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rc (
        .field(fld.rc), .en(state == S_T4), .onehot(rc_oh), .out_of_range(rc_oor)
    );

    assign bus.r_in  = ra_oh;
    assign bus.r_out = rb_oh | rc_oh;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.run) state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    if (bus.mem_ready) state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3: begin
                if (alu_ok)       state_nxt = S_T4;
                else if (is_halt) state_nxt = S_HALT;
                else              state_nxt = S_T0;
            end
            S_T4:    state_nxt = S_T5;
            S_T5:    state_nxt = S_T0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        bus.pc_out     = 1'b0;
        bus.mar_in     = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.pc_in      = 1'b0;
        bus.read       = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.ir_in      = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_in       = 1'b0;
        bus.zlow_out   = 1'b0;
        bus.alu_op     = '0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.halted     = 1'b0;
        case (state)
            S_T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
            end
            S_T1: begin
                // Incremented PC sits in Z; commit it once, when the fetch completes.
                bus.zlow_out = 1'b1;
                bus.read     = 1'b1;
                bus.mdr_in   = 1'b1;
                bus.pc_in    = bus.mem_ready;
            end
            S_T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            S_T3: begin
                bus.y_in       = alu_ok;
                bus.instr_done = !alu_ok && is_nop;
                bus.illegal    = !alu_ok && !is_nop && !is_halt;
            end
            S_T4: begin
                bus.z_in   = 1'b1;
                bus.alu_op = ALU_OP_W'(alu_code);
            end
            S_T5: begin
                bus.zlow_out   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stimulus queues the expected strobe vector per cycle,
// a negedge monitor pops and compares. Two instances: NUM_REGS=16 and NUM_REGS=8.
module tb_control_sequencer;

    typedef struct packed {
        logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [3:0]  alu_op;
        logic        instr_done, illegal, halted;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr16, clr8, run, mem_ready;
    logic [31:0] ir;
    bit          use8;
    int          total = 0;
    int          bad   = 0;
    obs_t        q16[$], q8[$];
    string       n16[$], n8[$];
    obs_t        act16, act8;

    always #5 clk = ~clk;

    control_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .ALU_OP_W(4)) bus16 ();
    control_sequencer_if #(.DATA_W(32), .NUM_REGS(8),  .ALU_OP_W(4)) bus8 ();

    assign bus16.run = run;  assign bus16.ir = ir;  assign bus16.mem_ready = mem_ready;
    assign bus8.run  = run;  assign bus8.ir  = ir;  assign bus8.mem_ready  = mem_ready;

    control_sequencer #(.DATA_W(32), .NUM_REGS(16), .ALU_OP_W(4)) dut16 (
        .clk(clk), .clr(clr16), .bus(bus16.master)
    );
    control_sequencer #(.DATA_W(32), .NUM_REGS(8), .ALU_OP_W(4)) dut8 (
        .clk(clk), .clr(clr8), .bus(bus8.master)
    );

    assign act16 = {bus16.pc_out, bus16.mar_in, bus16.inc_pc, bus16.pc_in, bus16.read, bus16.mdr_in,
                    bus16.mdr_out, bus16.ir_in, bus16.y_in, bus16.z_in, bus16.zlow_out,
                    bus16.r_in, bus16.r_out, bus16.alu_op, bus16.instr_done, bus16.illegal, bus16.halted};
    assign act8  = {bus8.pc_out, bus8.mar_in, bus8.inc_pc, bus8.pc_in, bus8.read, bus8.mdr_in,
                    bus8.mdr_out, bus8.ir_in, bus8.y_in, bus8.z_in, bus8.zlow_out,
                    8'h00, bus8.r_in, 8'h00, bus8.r_out, bus8.alu_op, bus8.instr_done, bus8.illegal, bus8.halted};

    // Expected strobe vectors, one per control step.
    function automatic obs_t f_t0();
        obs_t o = '0; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; return o;
    endfunction
    function automatic obs_t f_t1(input logic pcin);
        obs_t o = '0; o.zlow_out = 1; o.read = 1; o.mdr_in = 1; o.pc_in = pcin; return o;
    endfunction
    function automatic obs_t f_t2();
        obs_t o = '0; o.mdr_out = 1; o.ir_in = 1; return o;
    endfunction
    function automatic obs_t f_t3(input logic [15:0] rout);
        obs_t o = '0; o.r_out = rout; o.y_in = 1; return o;
    endfunction
    function automatic obs_t f_t4(input logic [15:0] rout, input logic [3:0] op);
        obs_t o = '0; o.r_out = rout; o.z_in = 1; o.alu_op = op; return o;
    endfunction
    function automatic obs_t f_t5(input logic [15:0] rin);
        obs_t o = '0; o.r_in = rin; o.zlow_out = 1; o.instr_done = 1; return o;
    endfunction
    function automatic obs_t f_done();
        obs_t o = '0; o.instr_done = 1; return o;
    endfunction
    function automatic obs_t f_ill();
        obs_t o = '0; o.illegal = 1; return o;
    endfunction
    function automatic obs_t f_halt();
        obs_t o = '0; o.halted = 1; return o;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input obs_t e, input string nm);
        if (use8) begin q8.push_back(e);  n8.push_back(nm);  end
        else      begin q16.push_back(e); n16.push_back(nm); end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits, input string nm);
        step(f_t0(), {nm, "_t0"});
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) step(f_t1(1'b0), {nm, "_t1wait"});
        mem_ready = 1'b1;
        step(f_t1(1'b1), {nm, "_t1"});
        step(f_t2(), {nm, "_t2"});
    endtask

    always @(negedge clk) begin
        obs_t  e;
        string n;
        if (q16.size() > 0) begin
            e = q16.pop_front(); n = n16.pop_front(); total++;
            if (act16 !== e) begin
                bad++;
                $display("FAIL %s (R16) got=%h want=%h", n, act16, e);
            end
        end
        if (q8.size() > 0) begin
            e = q8.pop_front(); n = n8.pop_front(); total++;
            if (act8 !== e) begin
                bad++;
                $display("FAIL %s (R8) got=%h want=%h", n, act8, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [4:0] bad_ops [4] = '{5'd0, 5'd2, 5'd11, 5'd31};
        clr16 = 1; clr8 = 1; run = 0; mem_ready = 1; ir = '0; use8 = 0;
        repeat (2) @(posedge clk);
        #1;
        step('0, "reset");
        clr16 = 0; run = 1;
        step('0, "idle_run");
        run = 0;

        // AND R1 <- R2 & R3
        fetch(0, "and");
        ir = 32'h28918000;
        step(f_t3(16'h0004), "and_t3");
        step(f_t4(16'h0008, 4'd3), "and_t4");
        step(f_t5(16'h0002), "and_t5");

        // Memory wait of 3 cycles, then NOP retiring in T3
        fetch(3, "wait");
        ir = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        step(f_done(), "nop_t3");

        for (int i = 3; i <= 10; i++) begin
            fetch(0, "sweep");
            ir = mk_ir(5'(i), 4'd4, 4'd5, 4'd6);
            step(f_t3(16'h0020), "sweep_t3");
            step(f_t4(16'h0040, 4'(i - 2)), "sweep_t4");
            step(f_t5(16'h0010), "sweep_t5");
        end

        for (int i = 0; i < 4; i++) begin
            fetch(0, "badop");
            ir = mk_ir(bad_ops[i], 4'd1, 4'd2, 4'd3);
            step(f_ill(), "badop_t3");
        end

        // clr in T4 aborts the instruction
        fetch(0, "rst");
        ir = mk_ir(5'b00011, 4'd1, 4'd1, 4'd1);
        step(f_t3(16'h0002), "rst_t3");
        clr16 = 1;
        step(f_t4(16'h0002, 4'd1), "rst_t4");
        clr16 = 0;
        step('0, "rst_idle");
        step('0, "rst_idle2");
        run = 1;
        step('0, "rst_run");
        run = 0;
        fetch(0, "restart");
        ir = mk_ir(5'b00100, 4'd2, 4'd3, 4'd4);
        step(f_t3(16'h0008), "restart_t3");
        step(f_t4(16'h0010, 4'd2), "restart_t4");
        step(f_t5(16'h0004), "restart_t5");

        // clr during a T1 memory wait
        step(f_t0(), "t1clr_t0");
        mem_ready = 0;
        step(f_t1(1'b0), "t1clr_w0");
        step(f_t1(1'b0), "t1clr_w1");
        clr16 = 1;
        step(f_t1(1'b0), "t1clr_w2");
        clr16 = 0; mem_ready = 1;
        step('0, "t1clr_idle");
        run = 1;
        step('0, "halt_run");
        run = 0;

        fetch(0, "halt");
        ir = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        step('0, "halt_t3");
        run = 1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            step(f_halt(), "halt_hold");
        end
        mem_ready = 1; clr16 = 1;
        step(f_halt(), "halt_clr");
        clr16 = 0; run = 0;
        step('0, "halt_idle");
        step('0, "halt_idle2");

        // NUM_REGS=8 instance: register fields >= 8 are illegal
        clr16 = 1; use8 = 1;
        step('0, "r8_reset");
        clr8 = 0; run = 1;
        step('0, "r8_idle_run");
        run = 0;
        fetch(0, "r8_rb9");
        ir = mk_ir(5'b00011, 4'd1, 4'd9, 4'd2);
        step(f_ill(), "r8_rb9_t3");
        fetch(0, "r8_rc8");
        ir = mk_ir(5'b00100, 4'd7, 4'd3, 4'd8);
        step(f_ill(), "r8_rc8_t3");
        fetch(0, "r8_ra15");
        ir = mk_ir(5'b00110, 4'd15, 4'd1, 4'd1);
        step(f_ill(), "r8_ra15_t3");
        fetch(0, "r8_ok");
        ir = mk_ir(5'b00011, 4'd7, 4'd0, 4'd6);
        step(f_t3(16'h0001), "r8_ok_t3");
        step(f_t4(16'h0040, 4'd1), "r8_ok_t4");
        step(f_t5(16'h0080), "r8_ok_t5");
        step(f_t0(), "r8_next_t0");

        @(negedge clk);
        #1;
        if (q16.size() != 0 || q8.size() != 0) begin
            total++; bad++;
            $display("FAIL drain got=%0d want=0", q16.size() + q8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
